riscv_muldiv_unit: RTL and testbench

Sequential RV32M/RV64M multiply-divide unit that replaces the single-cycle combinational mul/div/rem arithmetic in the CPU datapath.
- Takes an operation with a valid/ready handshake and returns a tagged result with a valid/ready handshake.
- Multiply is either single-cycle registered or iterative; divide is iterative.
- Implements the RISC-V divide-by-zero and signed-overflow results exactly, which the combinational version does not.

---
 rtl/riscv_muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit
//   Sequential RV32M/RV64M multiply/divide unit. One operation at a time,
//   taken on a valid/ready handshake and returned with its rd tag on a
//   second valid/ready handshake. Multiply is registered in one cycle
//   (FAST_MUL=1) or iterative shift-add; divide is iterative restoring
//   division on magnitudes with sign fix-up at the end. Divide-by-zero and
//   signed overflow finish in one cycle with the architectural results.
//
//   state | meaning
//   IDLE  | ready for a new request
//   MUL   | iterative shift-add, one multiplier bit per cycle
//   DIV   | restoring division, one quotient bit per cycle
//   DONE  | result valid, held until the consumer takes it
//
// Ports
//   SYS_clk, SYS_reset       clock, synchronous active-high reset
//   MD_valid_in/ready_out    request handshake
//   MD_funct3, MD_rs1_data,
//   MD_rs2_data, MD_tag_in   operation, operands, rd tag
//   MD_flush                 abort whatever is in flight
//   MD_valid_out/ready_in    result handshake
//   MD_result, MD_tag_out    result and its tag
//   MD_busy                  unit not idle
module riscv_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 1,
  parameter int TAG_W    = 5
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic             MD_valid_in,
  output logic             MD_ready_out,
  input  logic [2:0]       MD_funct3,
  input  logic [XLEN-1:0]  MD_rs1_data,
  input  logic [XLEN-1:0]  MD_rs2_data,
  input  logic [TAG_W-1:0] MD_tag_in,
  input  logic             MD_flush,
  output logic             MD_valid_out,
  input  logic             MD_ready_in,
  output logic [XLEN-1:0]  MD_result,
  output logic [TAG_W-1:0] MD_tag_out,
  output logic             MD_busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic [TAG_W-1:0]  tag_q;
  logic              neg_q;      // negate product / quotient at the end
  logic              rem_neg_q;  // remainder takes the dividend's sign
  logic [XLEN-1:0]   a_q;        // multiplier (shifts right) or dividend -> quotient
  logic [XLEN-1:0]   b_q;        // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q;      // product accumulator; low XLEN bits are the partial remainder
  logic [XLEN-1:0]   result_q;
  logic              valid_q;

  // Operand decode at accept
  logic            is_div, a_signed, b_signed, a_sgn, b_sgn;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;

  assign is_div   = MD_funct3[2];
  assign a_signed = (MD_funct3 == 3'b001) | (MD_funct3 == 3'b010) | (is_div & ~MD_funct3[0]);
  assign b_signed = (MD_funct3 == 3'b001) | (is_div & ~MD_funct3[0]);
  assign a_sgn    = a_signed & MD_rs1_data[XLEN-1];
  assign b_sgn    = b_signed & MD_rs2_data[XLEN-1];
  assign mag_a    = a_sgn ? -MD_rs1_data : MD_rs1_data;
  assign mag_b    = b_sgn ? -MD_rs2_data : MD_rs2_data;
  assign div_zero = (MD_rs2_data == '0);
  assign div_ovf  = ~MD_funct3[0] & (MD_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (MD_rs2_data == '1);

  // Single-cycle product: both operands extended to 2*XLEN, product taken mod 2^(2*XLEN)
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{XLEN{a_sgn}}, MD_rs1_data};
  assign fast_b    = {{XLEN{b_sgn}}, MD_rs2_data};
  assign fast_prod = fast_a * fast_b;

  // One shift-add step: add into the upper half, then shift the whole accumulator right
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc_d, mul_prod;
  logic [XLEN-1:0]   mul_res;
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (a_q[0] ? b_q : {XLEN{1'b0}})};
  assign mul_acc_d = {mul_sum, acc_q[XLEN-1:1]};
  assign mul_prod  = neg_q ? -mul_acc_d : mul_acc_d;
  assign mul_res   = (op_q == 3'b000) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  // One restoring step; partial remainder stays below the divisor so XLEN bits suffice
  logic [XLEN:0]   div_rs;
  logic            div_ge;
  logic [XLEN-1:0] div_rem_d, div_quo_d, div_q, div_r, div_res;
  assign div_rs    = {acc_q[XLEN-1:0], a_q[XLEN-1]};
  assign div_ge    = (div_rs >= {1'b0, b_q});
  assign div_rem_d = div_ge ? (div_rs[XLEN-1:0] - b_q) : div_rs[XLEN-1:0];
  assign div_quo_d = {a_q[XLEN-2:0], div_ge};
  assign div_q     = neg_q ? -div_quo_d : div_quo_d;
  assign div_r     = rem_neg_q ? -div_rem_d : div_rem_d;
  assign div_res   = op_q[1] ? div_r : div_q;

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
    end else if (MD_flush) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MD_valid_in) begin
            op_q      <= MD_funct3;
            tag_q     <= MD_tag_in;
            cnt_q     <= CW'(XLEN-1);
            a_q       <= mag_a;
            b_q       <= mag_b;
            acc_q     <= '0;
            neg_q     <= a_sgn ^ b_sgn;
            rem_neg_q <= a_sgn;
            if (!is_div) begin
              if (FAST_MUL != 0) begin
                result_q <= (MD_funct3 == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
                valid_q  <= 1'b1;
                state_q  <= DONE;
              end else begin
                state_q <= MUL;
              end
            end else if (div_zero) begin
              result_q <= MD_funct3[1] ? MD_rs1_data : {XLEN{1'b1}};
              valid_q  <= 1'b1;
              state_q  <= DONE;
            end else if (div_ovf) begin
              result_q <= MD_funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
              valid_q  <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q <= DIV;
            end
          end
        end
        MUL: begin
          acc_q <= mul_acc_d;
          a_q   <= a_q >> 1;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            result_q <= mul_res;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        DIV: begin
          acc_q <= {{XLEN{1'b0}}, div_rem_d};
          a_q   <= div_quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            result_q <= div_res;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (MD_ready_in) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MD_ready_out = (state_q == IDLE);
  assign MD_busy      = (state_q != IDLE);
  assign MD_valid_out = valid_q;
  assign MD_result    = result_q;
  assign MD_tag_out   = tag_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
module tb_riscv_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Instance A: XLEN=32, FAST_MUL=1
  logic        a_reset, a_valid_in, a_ready_out, a_flush, a_valid_out, a_ready_in, a_busy;
  logic [2:0]  a_f3;
  logic [31:0] a_rs1, a_rs2, a_result;
  logic [4:0]  a_tag, a_tag_out;

  riscv_muldiv_unit #(.XLEN(32), .FAST_MUL(1), .TAG_W(5)) dut_a (
    .SYS_clk(clk), .SYS_reset(a_reset), .MD_valid_in(a_valid_in), .MD_ready_out(a_ready_out),
    .MD_funct3(a_f3), .MD_rs1_data(a_rs1), .MD_rs2_data(a_rs2), .MD_tag_in(a_tag),
    .MD_flush(a_flush), .MD_valid_out(a_valid_out), .MD_ready_in(a_ready_in),
    .MD_result(a_result), .MD_tag_out(a_tag_out), .MD_busy(a_busy));

  // Instance B: XLEN=64, FAST_MUL=0
  logic        b_reset, b_valid_in, b_ready_out, b_flush, b_valid_out, b_ready_in, b_busy;
  logic [2:0]  b_f3;
  logic [63:0] b_rs1, b_rs2, b_result;
  logic [4:0]  b_tag, b_tag_out;

  riscv_muldiv_unit #(.XLEN(64), .FAST_MUL(0), .TAG_W(5)) dut_b (
    .SYS_clk(clk), .SYS_reset(b_reset), .MD_valid_in(b_valid_in), .MD_ready_out(b_ready_out),
    .MD_funct3(b_f3), .MD_rs1_data(b_rs1), .MD_rs2_data(b_rs2), .MD_tag_in(b_tag),
    .MD_flush(b_flush), .MD_valid_out(b_valid_out), .MD_ready_in(b_ready_in),
    .MD_result(b_result), .MD_tag_out(b_tag_out), .MD_busy(b_busy));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model for XLEN=32
  function automatic logic [31:0] ref32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    longint qa, qb;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    qa  = $signed(sa);
    qb  = $signed(sb);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = qa / qb;
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = qa % qb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op on instance A, hold the result for `hold` cycles, then consume it
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tg, input int hold);
    exp_t e;
    int acc, lat, n;
    logic [31:0] held;
    logic [4:0]  held_tag;
    e.res = ref32(f, a, b);
    e.tag = tg;
    e.lat = (!f[2] || b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
    sb_q.push_back(e);
    @(negedge clk);
    a_valid_in = 1'b1; a_f3 = f; a_rs1 = a; a_rs2 = b; a_tag = tg; a_ready_in = 1'b0;
    n = 0;
    while (!a_ready_out && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    acc = cyc;
    a_valid_in = 1'b0;
    a_f3 = 3'($urandom); a_rs1 = $urandom; a_rs2 = $urandom; a_tag = 5'($urandom);
    @(negedge clk);
    n = 0;
    while (!a_valid_out && n < 200) begin @(negedge clk); n++; end
    if (!a_valid_out) begin
      chk("valid_timeout", a_valid_out, 1);
      void'(sb_q.pop_front());
      return;
    end
    lat = cyc - acc + 1;
    held = a_result;
    held_tag = a_tag_out;
    repeat (hold) begin
      chk("bp_ready_out", a_ready_out, 0);
      @(negedge clk);
      chk("bp_valid", a_valid_out, 1);
      chk("bp_result", a_result, held);
      chk("bp_tag", a_tag_out, held_tag);
    end
    e = sb_q.pop_front();
    chk("result", a_result, e.res);
    chk("tag", a_tag_out, e.tag);
    chk("latency", lat, e.lat);
    a_ready_in = 1'b1;
    @(posedge clk); #1;
    chk("idle_after", a_ready_out, 1);
    chk("valid_drop", a_valid_out, 0);
    a_ready_in = 1'b0;
  endtask

  initial begin
    int acc, n, seen;
    a_reset = 1; a_valid_in = 0; a_flush = 0; a_ready_in = 0; a_f3 = 0; a_rs1 = 0; a_rs2 = 0; a_tag = 0;
    b_reset = 1; b_valid_in = 0; b_flush = 0; b_ready_in = 0; b_f3 = 0; b_rs1 = 0; b_rs2 = 0; b_tag = 0;
    repeat (3) @(negedge clk);
    a_reset = 0; b_reset = 0;
    @(posedge clk); #1;
    chk("rst_ready", a_ready_out, 1);
    chk("rst_valid", a_valid_out, 0);
    chk("rst_result", a_result, 0);
    chk("rst_tag", a_tag_out, 0);
    chk("rst_busy", a_busy, 0);

    // Fast multiply
    run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 5'h01, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'h02, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h04, 0);
    // Iterative divide
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'h05, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'h06, 0);
    run_op(3'd5, 32'd100, 32'd7, 5'h07, 0);
    run_op(3'd7, 32'd100, 32'd7, 5'h08, 0);
    // Special cases
    run_op(3'd4, 32'd5, 32'd0, 5'h09, 0);
    run_op(3'd6, 32'd5, 32'd0, 5'h0A, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0B, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0C, 0);
    // Back-pressure
    run_op(3'd5, 32'd1000, 32'd9, 5'h1A, 3);
    // Random mix, with some zero divisors and overflow operands
    for (int i = 0; i < 10; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'h0 : $urandom;
      if (i == 5) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      run_op(3'($urandom_range(0, 7)), ra, rb, 5'(i), 0);
    end

    // Flush in the middle of a divide
    @(negedge clk);
    a_valid_in = 1; a_f3 = 3'd4; a_rs1 = 32'd1000; a_rs2 = 32'd3; a_tag = 5'h11;
    @(posedge clk); #1;
    a_valid_in = 0;
    repeat (9) @(negedge clk);
    a_flush = 1;
    @(posedge clk); #1;
    a_flush = 0;
    chk("flush_ready", a_ready_out, 1);
    chk("flush_busy", a_busy, 0);
    chk("flush_valid", a_valid_out, 0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (a_valid_out) seen++; end
    chk("flush_no_valid", seen, 0);

    // Flush beats a same-cycle accept
    @(negedge clk);
    a_valid_in = 1; a_flush = 1; a_f3 = 3'd0; a_rs1 = 32'd5; a_rs2 = 32'd5;
    @(posedge clk); #1;
    a_valid_in = 0; a_flush = 0;
    chk("flush_drop_busy", a_busy, 0);
    seen = 0;
    repeat (5) begin @(negedge clk); if (a_valid_out) seen++; end
    chk("flush_drop_valid", seen, 0);

    run_op(3'd0, 32'd3, 32'd4, 5'h12, 0);

    // Instance B: iterative 64-bit multiply
    @(negedge clk);
    b_valid_in = 1; b_f3 = 3'd0; b_rs1 = 64'hFFFF_FFFF_FFFF_FFFF; b_rs2 = 64'd2; b_tag = 5'h15;
    @(posedge clk); #1;
    acc = cyc;
    b_valid_in = 0; b_rs1 = 0; b_rs2 = 0;
    n = 0;
    @(negedge clk);
    while (!b_valid_out && n < 200) begin @(negedge clk); n++; end
    chk("b_valid", b_valid_out, 1);
    chk("b_result", b_result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("b_tag", b_tag_out, 5'h15);
    chk("b_latency", cyc - acc + 1, 65);
    b_ready_in = 1;
    @(posedge clk); #1;
    b_ready_in = 0;
    chk("b_idle", b_ready_out, 1);

    // Reset mid-operation on B
    @(negedge clk);
    b_valid_in = 1; b_f3 = 3'd3; b_rs1 = 64'd12345; b_rs2 = 64'd678; b_tag = 5'h16;
    @(posedge clk); #1;
    b_valid_in = 0;
    repeat (19) @(negedge clk);
    b_reset = 1;
    @(posedge clk); #1;
    b_reset = 0;
    chk("b_rst_valid", b_valid_out, 0);
    chk("b_rst_result", b_result, 0);
    chk("b_rst_tag", b_tag_out, 0);
    chk("b_rst_busy", b_busy, 0);
    chk("b_rst_ready", b_ready_out, 1);
    b_ready_in = 1;
    seen = 0;
    repeat (80) begin @(negedge clk); if (b_valid_out) seen++; end
    chk("b_rst_no_valid", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
